// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM main controller.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH,
    UNKNOWN
  } statetype;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_CMP = 4'b1010;

  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
    logic       mem_req;
  } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// Per-state control table; purely combinational.
module mc_out_decode
  import mc_pkg::*;
(
  input  statetype   state_i,
  input  logic [3:0] rd_i,
  input  logic [3:0] cmd_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  logic rd_pc;
  logic nowrite;

  assign rd_pc   = (rd_i == 4'd15);
  assign nowrite = (cmd_i == CMD_CMP);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.alusrca   = 1'b1;
        ctrl_o.alusrcb   = SRCB_FOUR;
        ctrl_o.resultsrc = RES_ALU;
        ctrl_o.irwrite   = mem_ready_i;
        ctrl_o.pcwrite   = mem_ready_i;
      end
      DECODE: begin
        ctrl_o.alusrca   = 1'b1;
        ctrl_o.alusrcb   = SRCB_FOUR;
        ctrl_o.resultsrc = RES_ALU;
      end
      MEMADR: begin
        ctrl_o.alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.adrsrc  = 1'b1;
      end
      MEMWB: begin
        ctrl_o.resultsrc = RES_RDATA;
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.pcwrite   = rd_pc;
      end
      MEMWR: begin
        ctrl_o.mem_req  = 1'b1;
        ctrl_o.adrsrc   = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      EXECR: begin
        ctrl_o.alusrcb = SRCB_REG;
        ctrl_o.aluop   = 1'b1;
      end
      EXECI: begin
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = 1'b1;
      end
      ALUWB: begin
        ctrl_o.resultsrc = RES_ALUOUT;
        ctrl_o.regwrite  = ~nowrite;
        ctrl_o.pcwrite   = rd_pc & ~nowrite;
      end
      BRANCH: begin
        ctrl_o.alusrcb   = SRCB_IMM;
        ctrl_o.resultsrc = RES_ALU;
        ctrl_o.pcwrite   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle ARM main control FSM: state register, sequencing,
// stall gating and retired-instruction counter.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             ALUOp,
  output logic             mem_req,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  statetype         state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;
  logic             retire;
  ctrl_t            ctrl;

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        unique case (Op)
          OP_DP:   state_d = Funct[5] ? EXECI : EXECR;
          OP_MEM:  state_d = MEMADR;
          OP_BR:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:  state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
      EXECR:   state_d = ALUWB;
      EXECI:   state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  // UNKNOWN returns to FETCH without counting as a retirement.
  assign retire = (state_d == FETCH) &&
                  ((state_q == MEMWB) || (state_q == ALUWB) ||
                   (state_q == BRANCH) || (state_q == MEMWR));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else if (!stall) begin
      state_q <= state_d;
      if (retire)
        retired_q <= retired_q + CNT_W'(1);
      if (state_q == UNKNOWN)
        illegal_q <= 1'b1;
    end
  end

  mc_out_decode u_dec (
    .state_i     (state_q),
    .rd_i        (Rd),
    .cmd_i       (Funct[4:1]),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  logic wr_en;
  assign wr_en = reset & ~stall;

  assign IRWrite   = wr_en & ctrl.irwrite;
  assign PCWrite   = wr_en & ctrl.pcwrite;
  assign RegWrite  = wr_en & ctrl.regwrite;
  assign MemWrite  = wr_en & ctrl.memwrite;
  assign AdrSrc    = reset & ctrl.adrsrc;
  assign ALUSrcA   = reset & ctrl.alusrca;
  assign ALUSrcB   = reset ? ctrl.alusrcb : 2'b00;
  assign ResultSrc = reset ? ctrl.resultsrc : 2'b00;
  assign ALUOp     = reset & ctrl.aluop;
  assign mem_req   = reset & ctrl.mem_req;
  assign illegal   = illegal_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Random instruction stream against an instruction-level model
// of the multicycle controller.
module tb_mc_control_fsm;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             stall;
  logic [1:0]       Op;
  logic [5:0]       Funct;
  logic [3:0]       Rd;
  logic             mem_ready;
  logic             IRWrite, PCWrite, RegWrite, MemWrite;
  logic             AdrSrc, ALUSrcA, ALUOp, mem_req, illegal;
  logic [1:0]       ALUSrcB, ResultSrc;
  logic [CNT_W-1:0] retired;

  mc_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .Op        (Op),
    .Funct     (Funct),
    .Rd        (Rd),
    .mem_ready (mem_ready),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp),
    .mem_req   (mem_req),
    .illegal   (illegal),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [11:0] got_ctl;
  assign got_ctl = {IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc,
                    ALUSrcA, ALUSrcB, ResultSrc, ALUOp, mem_req};

  string       step;
  string       plan[$];
  int unsigned m_ret;
  bit          m_ill;

  task automatic model_reset();
    step  = "FETCH";
    plan.delete();
    m_ret = 0;
    m_ill = 0;
  endtask

  function automatic logic [11:0] exp_ctl(input string s,
                                          input logic st,
                                          input logic mr,
                                          input logic [5:0] f,
                                          input logic [3:0] r);
    logic irw, pcw, rw, mw, adr, sa, aop, mq;
    logic [1:0] sb, rs;
    logic cmp;
    {irw, pcw, rw, mw, adr, sa, aop, mq} = '0;
    sb  = 2'b00;
    rs  = 2'b00;
    cmp = (f[4:1] == 4'b1010);
    if (s == "FETCH") begin
      mq = 1; sa = 1; sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr;
    end else if (s == "DECODE") begin
      sa = 1; sb = 2'b10; rs = 2'b10;
    end else if (s == "MEMADR") begin
      sb = 2'b01;
    end else if (s == "MEMRD") begin
      mq = 1; adr = 1;
    end else if (s == "MEMWB") begin
      rs = 2'b01; rw = 1; pcw = (r == 15);
    end else if (s == "MEMWR") begin
      mq = 1; adr = 1; mw = 1;
    end else if (s == "EXECR") begin
      aop = 1;
    end else if (s == "EXECI") begin
      sb = 2'b01; aop = 1;
    end else if (s == "ALUWB") begin
      rw = !cmp; pcw = (r == 15) && !cmp;
    end else if (s == "BRANCH") begin
      sb = 2'b01; rs = 2'b10; pcw = 1;
    end
    if (st) begin
      irw = 0; pcw = 0; rw = 0; mw = 0;
    end
    return {irw, pcw, rw, mw, adr, sa, sb, rs, aop, mq};
  endfunction

  task automatic model_step(input logic st, input logic mr);
    if (st) return;
    if (step == "FETCH") begin
      if (mr) step = "DECODE";
      return;
    end
    if (step == "DECODE") begin
      case (Op)
        2'b00: begin
          plan.push_back(Funct[5] ? "EXECI" : "EXECR");
          plan.push_back("ALUWB");
        end
        2'b01: begin
          plan.push_back("MEMADR");
          if (Funct[0]) begin
            plan.push_back("MEMRD");
            plan.push_back("MEMWB");
          end else begin
            plan.push_back("MEMWR");
          end
        end
        2'b10: plan.push_back("BRANCH");
        default: plan.push_back("UNKNOWN");
      endcase
      step = plan.pop_front();
      return;
    end
    if ((step == "MEMRD" || step == "MEMWR") && !mr) return;
    if (plan.size() > 0) begin
      step = plan.pop_front();
    end else begin
      if (step == "UNKNOWN") m_ill = 1;
      else m_ret++;
      step = "FETCH";
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {20'd0, got_ctl}, 32'd0);
    check({tag, "_ill"}, {31'd0, illegal}, 32'd0);
    check({tag, "_ret"}, {28'd0, retired}, 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    stall     = 1'b0;
    mem_ready = 1'b0;
    Op        = 2'b00;
    Funct     = 6'd0;
    Rd        = 4'd0;
    model_reset();
    #3;
    check_reset_outputs("rst0");
    @(negedge clk);
    reset = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 577 == 576) begin
        #2 reset = 1'b0;
        #1 check_reset_outputs("arst");
        @(negedge clk);
        check_reset_outputs("arst_hold");
        reset = 1'b1;
        model_reset();
      end
      if (step == "FETCH") begin
        Op    = 2'($urandom_range(0, 3));
        Funct = 6'($urandom);
        if ($urandom % 4 == 0) Funct[4:1] = 4'b1010;
        Rd    = ($urandom % 4 == 0) ? 4'd15 : 4'($urandom);
      end
      stall     = ($urandom % 8 == 0);
      mem_ready = ($urandom % 4 != 0);
      #1;
      check({"ctl_", step}, {20'd0, got_ctl},
            {20'd0, exp_ctl(step, stall, mem_ready, Funct, Rd)});
      check("illegal", {31'd0, illegal}, {31'd0, m_ill});
      check("retired", {28'd0, retired}, m_ret % (1 << CNT_W));
      model_step(stall, mem_ready);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control FSM for the multicycle ARM core. Sequences fetch, decode, execute, memory and writeback over shared datapath resources: one memory port, one ALU, the register file write port and the IR/PC enables.
- Sits beside the decoder: it consumes the instruction fields latched in the IR and emits per-cycle enables and mux selects.
- Supports memory wait states through a ready handshake, a global stall, and illegal-opcode detection.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  freeze: hold state and counter; force every write enable to 0.
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L.
- Rd  in  4  Instr[15:12].
- mem_ready  in  1  memory access completes this cycle.
- IRWrite  out  1  load the instruction register.
- PCWrite  out  1  load the PC.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write strobe.
- AdrSrc  out  1  memory address select: 0=PC, 1=Result.
- ALUSrcA  out  1  ALU A select: 0=Rn, 1=PC.
- ALUSrcB  out  2  ALU B select: 00=Rm/WriteData, 01=ExtImm, 10=const 4.
- ResultSrc  out  2  result select: 00=ALUOut, 01=ReadData, 10=ALUResult.
- ALUOp  out  1  1=decode the ALU command from Funct; 0=add.
- mem_req  out  1  a memory access is in progress.
- illegal  out  1  sticky: an Op=11 instruction was decoded.
- retired  out  CNT_W  count of instructions completed.

Behaviour:
- Reset (reset=0), asynchronous:
  - state=FETCH, retired=0, illegal=0.
  - All outputs are forced to 0 while reset is low.
- Outputs are Moore, decoded from state. Exceptions: IRWrite and PCWrite in FETCH are qualified by mem_ready.
- stall=1:
  - State and retired are held.
  - IRWrite, PCWrite, RegWrite and MemWrite are forced to 0; selects keep their state values.
  - stall has priority over mem_ready.
- State outputs (unlisted outputs are 0):
  - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10. IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (produces PC+8 for R15 reads).
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD: mem_req=1, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1, PCWrite=(Rd==15).
  - MEMWR: mem_req=1, AdrSrc=1, MemWrite=1. Hold MemWrite until mem_ready.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00. RegWrite=~nowrite, PCWrite=(Rd==15)&~nowrite, where nowrite = (Funct[4:1]==4'b1010), i.e. CMP.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=1.
  - UNKNOWN: no enables.
- Transitions (all taken only when stall=0):
  - FETCH -> DECODE when mem_ready, else stay in FETCH.
  - DECODE:
    - Op=00 -> EXECI if Funct[5], else EXECR.
    - Op=01 -> MEMADR.
    - Op=10 -> BRANCH.
    - Op=11 -> UNKNOWN.
  - MEMADR -> MEMRD if Funct[0], else MEMWR.
  - MEMRD -> MEMWB on mem_ready, else stay.
  - MEMWR -> FETCH on mem_ready, else stay.
  - EXECR, EXECI -> ALUWB.
  - MEMWB, ALUWB, BRANCH -> FETCH.
  - UNKNOWN -> FETCH. illegal is set to 1 and is cleared only by reset.
  - Any undefined state encoding -> FETCH.
- retired:
  - Increments by 1 on every transition into FETCH from MEMWB, ALUWB, BRANCH or MEMWR.
  - UNKNOWN does not count.
  - Wraps modulo 2^CNT_W.
- Latencies, with mem_ready held at 1: data-processing 4 cycles, LDR 5, STR 4, B 3.
- reset low mid-instruction aborts the instruction immediately; there is no partial write after reset is released.

Decomposition:
- Package mc_pkg holds:
  - typedef enum logic [3:0] statetype: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, UNKNOWN.
  - Localparams for the ALUSrcB and ResultSrc encodings, the Op codes (OP_DP=00, OP_MEM=01, OP_BR=10) and CMD_CMP=4'b1010.
- One sub-module, mc_out_decode: purely combinational state/Rd/Funct/mem_ready -> output table.
- The state register, next-state logic, stall gating and counter stay in the top level.

Test Plan:
- ADD R1,R2,R3 (Op=00, Funct=001000, Rd=1), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB. RegWrite=1 only in ALUWB. retired goes 0 -> 1.
- LDR R15 (Op=01, Funct[0]=1, Rd=15), mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles. MEMWB asserts RegWrite=1 and PCWrite=1. Total 7 cycles.
- STR (Funct[0]=0) with mem_ready=0 for 1 cycle -> MemWrite=1 for 2 cycles, AdrSrc=1, then FETCH. RegWrite never 1.
- CMP (Funct[4:1]=1010) then B (Op=10) -> RegWrite=0 in ALUWB. BRANCH asserts PCWrite=1 with ALUSrcB=01. retired=2.
- Op=11 -> UNKNOWN, then FETCH. illegal=1 and stays 1 across 3 further instructions. retired is unchanged by the bad instruction.
- stall=1 for 3 cycles in EXECI, then reset pulsed low in MEMRD -> state and outputs frozen with enables 0 during the stall. On reset: state=FETCH, retired=0, illegal=0 asynchronously.
